// File: rtl/reg_fwd_fsm.sv
// reg_fwd_fsm: forwards an upstream register request to one decoded child port and returns its response
module reg_fwd_fsm #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 32,
  parameter int N_CHILD = 5,
  parameter int SEL_LSB = 16,
  parameter int SEL_W = 3,
  parameter logic [31:0] ERR_DATA = 32'h0bad_add2
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic                          up_req_vld,
  input  logic [ADDR_WIDTH-1:0]         up_addr,
  input  logic                          up_wr_en,
  input  logic                          up_rd_en,
  input  logic [DATA_WIDTH-1:0]         up_wr_data,
  input  logic                          up_non_sec,
  input  logic                          up_abort,
  output logic                          up_ack_vld,
  output logic [DATA_WIDTH-1:0]         up_rd_data,
  output logic                          up_err,
  output logic [N_CHILD-1:0]            dn_req_vld,
  output logic [ADDR_WIDTH-1:0]         dn_addr,
  output logic                          dn_wr_en,
  output logic                          dn_rd_en,
  output logic [DATA_WIDTH-1:0]         dn_wr_data,
  output logic                          dn_non_sec,
  input  logic [N_CHILD-1:0]            dn_ack_vld,
  input  logic [N_CHILD*DATA_WIDTH-1:0] dn_rd_data,
  input  logic [N_CHILD-1:0]            dn_err
);
  typedef enum logic [1:0] {S_IDLE, S_FWD, S_WAIT, S_ERR} state_t;
  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_wr_en, r_rd_en, r_non_sec;
  logic [SEL_W-1:0]      r_idx;
  logic [SEL_W-1:0]      w_idx;
  logic                  w_hit, w_busy, w_fwd, w_resp, w_ack, w_cerr;
  logic [DATA_WIDTH-1:0] w_cdata;

  assign w_idx  = up_addr[SEL_LSB +: SEL_W];
  assign w_hit  = {1'b0, w_idx} < (SEL_W+1)'(N_CHILD);
  assign w_fwd  = r_state == S_FWD;
  assign w_busy = w_fwd || r_state == S_WAIT;
  assign w_resp = w_busy && w_ack;

  // pick ack, error and read data of the latched child only
  always_comb begin
    w_ack = 1'b0;
    w_cerr = 1'b0;
    w_cdata = '0;
    for (int i = 0; i < N_CHILD; i++)
      if (r_idx == SEL_W'(i)) begin
        w_ack = dn_ack_vld[i];
        w_cerr = dn_err[i];
        w_cdata = dn_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end

  // next state: the child's ack beats an abort; a decode error always answers once
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = up_req_vld ? (w_hit ? S_FWD : S_ERR) : S_IDLE;
      S_FWD:   w_next = (w_ack || up_abort) ? S_IDLE : S_WAIT;
      S_WAIT:  w_next = (w_ack || up_abort) ? S_IDLE : S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end

  // state register and request latches, captured only when a request is accepted
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= S_IDLE;
      r_addr <= '0;
      r_wr_data <= '0;
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_non_sec <= 1'b0;
      r_idx <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && up_req_vld) begin
        r_addr <= up_addr;
        r_wr_data <= up_wr_data;
        r_wr_en <= up_wr_en;
        r_rd_en <= up_rd_en;
        r_non_sec <= up_non_sec;
        r_idx <= w_idx;
      end
    end
  end

  // downstream pulse lasts exactly the S_FWD cycle; everything is quiet otherwise
  always_comb begin
    dn_req_vld = w_fwd ? N_CHILD'(1) << r_idx : '0;
    dn_addr = w_fwd ? r_addr : '0;
    dn_wr_en = w_fwd && r_wr_en;
    dn_rd_en = w_fwd && r_rd_en;
    dn_wr_data = w_fwd ? r_wr_data : '0;
    dn_non_sec = w_fwd && r_non_sec;
  end

  // upstream response: same-cycle pass-through of the child ack, or the decode error reply
  always_comb begin
    up_ack_vld = w_resp || r_state == S_ERR;
    up_err = w_resp ? w_cerr : r_state == S_ERR;
    up_rd_data = !r_rd_en ? '0 : w_resp ? w_cdata : r_state == S_ERR ? DATA_WIDTH'(ERR_DATA) : '0;
  end
endmodule

// File: tb/tb_reg_fwd_fsm.sv
// tb_reg_fwd_fsm: directed and randomized checks of reg_fwd_fsm against a transaction-level model
module tb_reg_fwd_fsm;
  logic         pclk, presetn;
  logic         up_req_vld, up_wr_en, up_rd_en, up_non_sec, up_abort;
  logic [47:0]  up_addr;
  logic [31:0]  up_wr_data;
  logic         up_ack_vld, up_err;
  logic [31:0]  up_rd_data;
  logic [4:0]   dn_req_vld, dn_ack_vld, dn_err;
  logic [47:0]  dn_addr;
  logic         dn_wr_en, dn_rd_en, dn_non_sec;
  logic [31:0]  dn_wr_data;
  logic [159:0] dn_rd_data;
  int vectors = 0, miscompares = 0;

  reg_fwd_fsm dut (
    .pclk(pclk), .presetn(presetn), .up_req_vld(up_req_vld), .up_addr(up_addr),
    .up_wr_en(up_wr_en), .up_rd_en(up_rd_en), .up_wr_data(up_wr_data), .up_non_sec(up_non_sec),
    .up_abort(up_abort), .up_ack_vld(up_ack_vld), .up_rd_data(up_rd_data), .up_err(up_err),
    .dn_req_vld(dn_req_vld), .dn_addr(dn_addr), .dn_wr_en(dn_wr_en), .dn_rd_en(dn_rd_en),
    .dn_wr_data(dn_wr_data), .dn_non_sec(dn_non_sec), .dn_ack_vld(dn_ack_vld),
    .dn_rd_data(dn_rd_data), .dn_err(dn_err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // model: one outstanding transaction, described by its age in cycles since acceptance
  bit         busy, t_hit, t_wr, t_rd, t_ns;
  int         age, t_idx;
  logic [47:0] t_addr;
  logic [31:0] t_wd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    up_req_vld = 0; up_addr = '0; up_wr_en = 0; up_rd_en = 0; up_wr_data = '0;
    up_non_sec = 0; up_abort = 0; dn_ack_vld = '0; dn_err = '0; dn_rd_data = '0;
  endtask

  task automatic check();
    bit a, pulse;
    logic [4:0]  e_req;
    logic [31:0] e_rd;
    bit e_ack, e_err;
    #1;
    a = busy && t_hit && dn_ack_vld[t_idx];
    pulse = busy && t_hit && age == 1;
    e_req = pulse ? 5'(1 << t_idx) : 5'd0;
    e_ack = busy && (!t_hit || a);
    e_err = busy && (!t_hit || (a && dn_err[t_idx]));
    e_rd = !(busy && t_rd) ? 32'd0 : !t_hit ? 32'h0bad_add2 : a ? dn_rd_data[t_idx*32 +: 32] : 32'd0;
    chk("up_ack_vld", 64'(up_ack_vld), 64'(e_ack));
    chk("up_err", 64'(up_err), 64'(e_err));
    chk("up_rd_data", 64'(up_rd_data), 64'(e_rd));
    chk("dn_req_vld", 64'(dn_req_vld), 64'(e_req));
    chk("dn_addr", 64'(dn_addr), pulse ? 64'(t_addr) : 64'd0);
    chk("dn_wr_en", 64'(dn_wr_en), 64'(pulse && t_wr));
    chk("dn_rd_en", 64'(dn_rd_en), 64'(pulse && t_rd));
    chk("dn_wr_data", 64'(dn_wr_data), pulse ? 64'(t_wd) : 64'd0);
    chk("dn_non_sec", 64'(dn_non_sec), 64'(pulse && t_ns));
  endtask

  task automatic adv();
    if (!presetn) busy = 0;
    else if (!busy) begin
      if (up_req_vld) begin
        busy = 1; age = 1; t_idx = int'(up_addr[18:16]); t_hit = t_idx < 5;
        t_addr = up_addr; t_wr = up_wr_en; t_rd = up_rd_en; t_wd = up_wr_data; t_ns = up_non_sec;
      end
    end else if (!t_hit) busy = 0;
    else if (dn_ack_vld[t_idx] || up_abort) busy = 0;
    else age++;
    @(negedge pclk);
  endtask

  task automatic cyc();
    check();
    adv();
  endtask

  task automatic req(input logic [47:0] addr, input bit rd, input logic [31:0] wd);
    clr();
    up_req_vld = 1; up_addr = addr; up_rd_en = rd; up_wr_en = !rd; up_wr_data = wd;
    cyc();
    clr();
  endtask

  initial begin
    clr();
    presetn = 0; busy = 0; age = 0; t_idx = 0; t_hit = 0;
    @(negedge pclk);
    cyc();
    chk("reset_ack", 64'(up_ack_vld), 64'd0);
    chk("reset_req", 64'(dn_req_vld), 64'd0);
    presetn = 1;
    cyc();
    // read child 2, ack three cycles after its request
    req(48'h0000_0002_0040, 1, 32'h0);
    check();
    chk("rd2_req", 64'(dn_req_vld), 64'b00100);
    chk("rd2_addr", 64'(dn_addr), 64'h0000_0002_0040);
    chk("rd2_rden", 64'(dn_rd_en), 64'd1);
    adv();
    cyc();
    cyc();
    dn_ack_vld = 5'b00100; dn_rd_data[64 +: 32] = 32'h1234_5678;
    check();
    chk("rd2_ack", 64'(up_ack_vld), 64'd1);
    chk("rd2_data", 64'(up_rd_data), 64'h1234_5678);
    chk("rd2_err", 64'(up_err), 64'd0);
    adv();
    clr();
    // write child 0, same-cycle ack
    req(48'h0000_0000_0100, 0, 32'hcafe_f00d);
    dn_ack_vld = 5'b00001; dn_rd_data[31:0] = 32'hffff_ffff;
    check();
    chk("wr0_wren", 64'(dn_wr_en), 64'd1);
    chk("wr0_wdata", 64'(dn_wr_data), 64'hcafe_f00d);
    chk("wr0_ack", 64'(up_ack_vld), 64'd1);
    chk("wr0_rdata", 64'(up_rd_data), 64'd0);
    adv();
    clr();
    cyc();
    // decode error on idx 6
    req(48'h0000_0006_0000, 1, 32'h0);
    check();
    chk("err_req", 64'(dn_req_vld), 64'd0);
    chk("err_ack", 64'(up_ack_vld), 64'd1);
    chk("err_err", 64'(up_err), 64'd1);
    chk("err_data", 64'(up_rd_data), 64'h0bad_add2);
    adv();
    // child 3 with a spurious child-1 ack, then abort, then a late child-3 ack
    req(48'h0000_0003_0000, 1, 32'h0);
    cyc();
    dn_ack_vld = 5'b00010; dn_rd_data[32 +: 32] = 32'h1111_1111;
    check();
    chk("spur_ack", 64'(up_ack_vld), 64'd0);
    adv();
    clr();
    up_abort = 1;
    check();
    chk("abort_ack", 64'(up_ack_vld), 64'd0);
    adv();
    clr();
    dn_ack_vld = 5'b01000;
    check();
    chk("late_ack", 64'(up_ack_vld), 64'd0);
    adv();
    req(48'h0000_0003_0000, 1, 32'h0);
    check();
    chk("after_abort_req", 64'(dn_req_vld), 64'b01000);
    adv();
    dn_ack_vld = 5'b01000; dn_rd_data[96 +: 32] = 32'h3333_3333;
    cyc();
    clr();
    // child 4 ack with error racing an abort
    req(48'h0000_0004_0000, 1, 32'h0);
    cyc();
    dn_ack_vld = 5'b10000; dn_err = 5'b10000; up_abort = 1; dn_rd_data[128 +: 32] = 32'h4444_4444;
    check();
    chk("race_ack", 64'(up_ack_vld), 64'd1);
    chk("race_err", 64'(up_err), 64'd1);
    adv();
    clr();
    // reset while waiting
    req(48'h0000_0001_0000, 1, 32'h0);
    cyc();
    cyc();
    #2 presetn = 0;
    #1;
    chk("rst_ack", 64'(up_ack_vld), 64'd0);
    chk("rst_req", 64'(dn_req_vld), 64'd0);
    chk("rst_rden", 64'(dn_rd_en), 64'd0);
    busy = 0;
    @(negedge pclk);
    cyc();
    presetn = 1;
    req(48'h0000_0001_0000, 1, 32'h0);
    cyc();
    dn_ack_vld = 5'b00010; dn_rd_data[32 +: 32] = 32'h5555_aaaa;
    check();
    chk("post_rst_ack", 64'(up_ack_vld), 64'd1);
    chk("post_rst_data", 64'(up_rd_data), 64'h5555_aaaa);
    adv();
    clr();
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      up_req_vld = $urandom_range(0, 2) == 0;
      up_addr = {$urandom, $urandom} & 48'hffff_ffff_ffff;
      up_rd_en = $urandom_range(0, 1) == 1;
      up_wr_en = !up_rd_en;
      up_wr_data = $urandom;
      up_non_sec = $urandom_range(0, 1) == 1;
      up_abort = $urandom_range(0, 7) == 0;
      dn_ack_vld = 5'($urandom) & 5'($urandom);
      dn_err = 5'($urandom);
      dn_rd_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
